layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/cnn_pkg.sv | 54 +++++
 rtl/layer_desc_ram.sv | 26 ++
 rtl/layer_scheduler.sv | 153 +++++++++++++++
 tb/tb_layer_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer scheduler: FSM states,
// descriptor field layout and the core configuration bundle.
package cnn_pkg;

  localparam int unsigned MAX_LAYERS = 8;
  localparam int unsigned DESC_W     = 96;
  localparam int unsigned LAYER_W    = 3;
  localparam int unsigned NUM_W      = 4;

  // Descriptor layout, LSB-first; bits above CFG_W are reserved.
  localparam int unsigned CH_IN_OFF  = 0;
  localparam int unsigned CH_IN_W    = 12;
  localparam int unsigned STRIDE_OFF = 12;
  localparam int unsigned STRIDE_W   = 3;
  localparam int unsigned WIDTH_OFF  = 15;
  localparam int unsigned WIDTH_W    = 12;
  localparam int unsigned WEIGHT_OFF = 27;
  localparam int unsigned WEIGHT_W   = 32;
  localparam int unsigned CH_OUT_OFF = 59;
  localparam int unsigned CH_OUT_W   = 11;
  localparam int unsigned WXW_OFF    = 70;
  localparam int unsigned WXW_W      = 16;
  localparam int unsigned CFG_W      = 86;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [WXW_W-1:0]    wxw_out;
    logic [CH_OUT_W-1:0] no_channel_out;
    logic [WEIGHT_W-1:0] weight_size;
    logic [WIDTH_W-1:0]  width_input_img;
    logic [STRIDE_W-1:0] stride;
    logic [CH_IN_W-1:0]  channel_input_img;
  } core_cfg_t;

  function automatic core_cfg_t desc_to_cfg(input logic [CFG_W-1:0] raw);
    core_cfg_t c;
    c.channel_input_img = raw[CH_IN_OFF  +: CH_IN_W];
    c.stride            = raw[STRIDE_OFF +: STRIDE_W];
    c.width_input_img   = raw[WIDTH_OFF  +: WIDTH_W];
    c.weight_size       = raw[WEIGHT_OFF +: WEIGHT_W];
    c.no_channel_out    = raw[CH_OUT_OFF +: CH_OUT_W];
    c.wxw_out           = raw[WXW_OFF    +: WXW_W];
    return c;
  endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Layer descriptor table: one synchronous write port, one asynchronous read
// port. Contents are intentionally not reset.
module layer_desc_ram #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 96,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/layer_scheduler.sv
// Sequences a conv core through up to MAX_LAYERS layer descriptors, issuing
// one start pulse per layer and ping-ponging the image buffer select.
module layer_scheduler
  import cnn_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = cnn_pkg::MAX_LAYERS,
  parameter int unsigned DESC_W     = cnn_pkg::DESC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DESC_W-1:0] cfg_wdata,
  input  logic [3:0]        num_layers,
  input  logic              run_start,
  output logic              run_busy,
  output logic              run_done,
  output logic              run_err,
  output logic [2:0]        layer_idx,
  output logic [11:0]       channel_input_img,
  output logic [2:0]        stride,
  output logic [11:0]       width_input_img,
  output logic [31:0]       weight_size_1_16,
  output logic [10:0]       no_channel_out,
  output logic [15:0]       WxW_out,
  output logic              BRAM_img_sel,
  output logic              start_core_in,
  input  logic              end_core_out
);

  logic [DESC_W-1:0] rd_data;

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
  logic               bram_q, bram_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  core_cfg_t          cfg_q, cfg_d;

  logic run_valid_c;
  logic last_layer_c;
  logic unused_rsvd;

  layer_desc_ram #(
    .DEPTH  (MAX_LAYERS),
    .WIDTH  (DESC_W),
    .ADDR_W (LAYER_W)
  ) u_desc_ram (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (layer_idx_q),
    .rdata (rd_data)
  );

  assign unused_rsvd  = ^rd_data[DESC_W-1:CFG_W];
  assign run_valid_c  = (num_layers != '0) && (32'(num_layers) <= MAX_LAYERS);
  assign last_layer_c = ({1'b0, layer_idx_q} == (num_q - 4'd1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    layer_idx_d = layer_idx_q;
    bram_d      = bram_q;
    err_d       = err_q;
    cfg_d       = cfg_q;

    unique case (state_q)
      IDLE: begin
        if (run_start) begin
          if (run_valid_c) begin
            num_d       = num_layers;
            layer_idx_d = '0;
            bram_d      = 1'b0;
            err_d       = 1'b0;
            state_d     = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        cfg_d   = desc_to_cfg(rd_data[CFG_W-1:0]);
        state_d = START;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (end_core_out) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        bram_d = ~bram_q;
        if (last_layer_c) begin
          state_d = DONE;
        end else begin
          layer_idx_d = layer_idx_q + 3'd1;
          state_d     = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered copies of the state being entered.
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      layer_idx_q <= '0;
      bram_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_q       <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      layer_idx_q <= layer_idx_d;
      bram_q      <= bram_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cfg_q       <= cfg_d;
    end
  end

  assign run_busy          = busy_q;
  assign run_done          = done_q;
  assign run_err           = err_q;
  assign layer_idx         = layer_idx_q;
  assign BRAM_img_sel      = bram_q;
  assign start_core_in     = start_q;
  assign channel_input_img = cfg_q.channel_input_img;
  assign stride            = cfg_q.stride;
  assign width_input_img   = cfg_q.width_input_img;
  assign weight_size_1_16  = cfg_q.weight_size;
  assign no_channel_out    = cfg_q.no_channel_out;
  assign WxW_out           = cfg_q.wxw_out;

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: table-driven run requests, a
// scoreboard of expected per-layer configs, and a delayed-response core model.
module tb_layer_scheduler;

  typedef struct {
    logic [11:0] ch;
    logic [2:0]  stride;
    logic [11:0] width;
    logic [31:0] weight;
    logic [10:0] noch;
    logic [15:0] wxw;
  } desc_t;

  typedef struct {
    logic [2:0] idx;
    logic       bram;
    desc_t      d;
  } exp_t;

  typedef struct {
    logic [3:0] nl;
    logic       exp_err;
    logic       exp_busy;
    int         exp_starts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [95:0] cfg_wdata;
  logic [3:0]  num_layers;
  logic        run_start;
  logic        run_busy, run_done, run_err;
  logic [2:0]  layer_idx;
  logic [11:0] channel_input_img;
  logic [2:0]  stride;
  logic [11:0] width_input_img;
  logic [31:0] weight_size_1_16;
  logic [10:0] no_channel_out;
  logic [15:0] WxW_out;
  logic        BRAM_img_sel;
  logic        start_core_in;
  logic        end_core_out;

  logic core_end = 1'b0;
  logic spur_end = 1'b0;
  assign end_core_out = core_end | spur_end;

  layer_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_wdata         (cfg_wdata),
    .num_layers        (num_layers),
    .run_start         (run_start),
    .run_busy          (run_busy),
    .run_done          (run_done),
    .run_err           (run_err),
    .layer_idx         (layer_idx),
    .channel_input_img (channel_input_img),
    .stride            (stride),
    .width_input_img   (width_input_img),
    .weight_size_1_16  (weight_size_1_16),
    .no_channel_out    (no_channel_out),
    .WxW_out           (WxW_out),
    .BRAM_img_sel      (BRAM_img_sel),
    .start_core_in     (start_core_in),
    .end_core_out      (end_core_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  desc_t shadow [8];
  exp_t  exp_q [$];

  int core_dly = 10;
  bit core_en = 1'b1;
  bit chk_spacing = 1'b1;
  int cnt = 0;
  int n_starts = 0;
  int n_done = 0;
  int prev_start_cyc = -100;
  int last_start_cyc = -100;
  int done_cyc = -1;
  int run_start_cyc = 0;
  logic prev_done = 1'b0;

  // Core model plus scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    core_end = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && core_en) core_end = 1'b1;
    end
    if (run_done) begin
      n_done++;
      done_cyc = cyc;
      check("run_done_one_cycle", 64'(prev_done), 64'd0);
    end
    prev_done = run_done;
    if (start_core_in) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start: start_core_in at cycle %0d with no layer expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_layer_idx", 64'(layer_idx), 64'(e.idx));
        check("sb_bram_sel", 64'(BRAM_img_sel), 64'(e.bram));
        check("sb_channel_in", 64'(channel_input_img), 64'(e.d.ch));
        check("sb_stride", 64'(stride), 64'(e.d.stride));
        check("sb_width_in", 64'(width_input_img), 64'(e.d.width));
        check("sb_weight", 64'(weight_size_1_16), 64'(e.d.weight));
        check("sb_channel_out", 64'(no_channel_out), 64'(e.d.noch));
        check("sb_wxw", 64'(WxW_out), 64'(e.d.wxw));
        if (e.idx == 3'd0)
          check("first_start_latency", 64'(cyc - run_start_cyc), 64'd2);
        else if (chk_spacing)
          check("start_spacing", 64'(cyc - prev_start_cyc), 64'(core_dly + 3));
      end
      prev_start_cyc = cyc;
      last_start_cyc = cyc;
      if (core_en) cnt = core_dly;
    end
  end

  function automatic logic [95:0] pack(input desc_t d, input logic [9:0] rsv);
    return {rsv, d.wxw, d.noch, d.weight, d.width, d.stride, d.ch};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic write_desc(input int idx, input desc_t d, input logic [9:0] rsv);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(idx);
    cfg_wdata = pack(d, rsv);
    step();
    cfg_we    = 1'b0;
    shadow[idx] = d;
  endtask

  task automatic start_run(input logic [3:0] nl);
    exp_t e;
    num_layers    = nl;
    run_start     = 1'b1;
    run_start_cyc = cyc;
    if (nl >= 4'd1 && nl <= 4'd8) begin
      for (int i = 0; i < int'(nl); i++) begin
        e.idx  = 3'(i);
        e.bram = 1'(i);
        e.d    = shadow[i];
        exp_q.push_back(e);
      end
    end
    step();
    run_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (run_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_done_timeout: no run_done within %0d cycles", limit);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(run_busy), 64'd0);
    check({tag, "_done"}, 64'(run_done), 64'd0);
    check({tag, "_err"}, 64'(run_err), 64'd0);
    check({tag, "_layer_idx"}, 64'(layer_idx), 64'd0);
    check({tag, "_bram"}, 64'(BRAM_img_sel), 64'd0);
    check({tag, "_start"}, 64'(start_core_in), 64'd0);
    check({tag, "_cfg"}, 64'({channel_input_img, stride, width_input_img}) |
          64'(weight_size_1_16) | 64'({no_channel_out, WxW_out}), 64'd0);
  endtask

  initial begin
    vec_t  vecs [7];
    desc_t d, old0;
    int    s0, d0;

    vecs[0] = '{nl: 4'd0,  exp_err: 1'b1, exp_busy: 1'b0, exp_starts: 0};
    vecs[1] = '{nl: 4'd2,  exp_err: 1'b0, exp_busy: 1'b1, exp_starts: 2};
    vecs[2] = '{nl: 4'd9,  exp_err: 1'b1, exp_busy: 1'b0, exp_starts: 0};
    vecs[3] = '{nl: 4'd1,  exp_err: 1'b0, exp_busy: 1'b1, exp_starts: 1};
    vecs[4] = '{nl: 4'd15, exp_err: 1'b1, exp_busy: 1'b0, exp_starts: 0};
    vecs[5] = '{nl: 4'd3,  exp_err: 1'b0, exp_busy: 1'b1, exp_starts: 3};
    vecs[6] = '{nl: 4'd0,  exp_err: 1'b1, exp_busy: 1'b0, exp_starts: 0};

    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    num_layers = '0; run_start = 1'b0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b1;
    step();

    d = '{ch: 12'd2, stride: 3'd1, width: 12'd5, weight: 32'd36, noch: 11'd2, wxw: 16'd9};
    write_desc(0, d, 10'h3A5);
    d = '{ch: 12'd2, stride: 3'd1, width: 12'd3, weight: 32'd18, noch: 11'd2, wxw: 16'd1};
    write_desc(1, d, 10'h0F0);
    for (int i = 2; i < 8; i++) begin
      d.ch = 12'($urandom); d.stride = 3'($urandom); d.width = 12'($urandom);
      d.weight = $urandom; d.noch = 11'($urandom); d.wxw = 16'($urandom);
      write_desc(i, d, 10'($urandom));
    end

    // Run-request table: invalid counts set run_err, valid ones run to completion.
    for (int v = 0; v < 7; v++) begin
      s0 = n_starts;
      d0 = n_done;
      start_run(vecs[v].nl);
      check("vec_busy", 64'(run_busy), 64'(vecs[v].exp_busy));
      check("vec_err", 64'(run_err), 64'(vecs[v].exp_err));
      if (vecs[v].exp_busy) begin
        wait_done(300);
        check("vec_starts", 64'(n_starts - s0), 64'(vecs[v].exp_starts));
        check("vec_done_count", 64'(n_done - d0), 64'd1);
        check("vec_done_after_last", 64'(done_cyc - last_start_cyc), 64'(core_dly + 2));
        check("vec_bram_final", 64'(BRAM_img_sel), 64'(vecs[v].nl[0]));
        step();
        check("vec_busy_after", 64'(run_busy), 64'd0);
        check("vec_done_low_after", 64'(run_done), 64'd0);
      end else begin
        tick(5);
        check("vec_no_start", 64'(n_starts - s0), 64'd0);
        check("vec_idle_busy", 64'(run_busy), 64'd0);
        check("vec_err_sticky", 64'(run_err), 64'd1);
      end
    end

    // Spurious end_core_out in IDLE/LOAD, run_start during WAIT, write during WAIT.
    core_en = 1'b0;
    chk_spacing = 1'b0;
    s0 = n_starts;
    d0 = n_done;
    spur_end = 1'b1; step(); spur_end = 1'b0;
    tick(3);
    check("spur_idle_busy", 64'(run_busy), 64'd0);
    check("spur_idle_starts", 64'(n_starts - s0), 64'd0);
    start_run(4'd2);
    spur_end = 1'b1; step(); spur_end = 1'b0;
    tick(15);
    check("spur_load_layer", 64'(layer_idx), 64'd0);
    check("spur_load_starts", 64'(n_starts - s0), 64'd1);
    check("spur_load_busy", 64'(run_busy), 64'd1);
    num_layers = 4'd5; run_start = 1'b1; step(); run_start = 1'b0; num_layers = 4'd2;
    tick(3);
    check("restart_ignored_busy", 64'(run_busy), 64'd1);
    check("restart_ignored_err", 64'(run_err), 64'd0);
    check("restart_ignored_layer", 64'(layer_idx), 64'd0);
    old0 = shadow[0];
    d = '{ch: 12'hABC, stride: 3'd7, width: 12'h123, weight: 32'hDEADBEEF, noch: 11'h55, wxw: 16'h7777};
    write_desc(0, d, 10'h000);
    tick(2);
    check("wait_write_ch_stable", 64'(channel_input_img), 64'(old0.ch));
    check("wait_write_weight_stable", 64'(weight_size_1_16), 64'(old0.weight));
    spur_end = 1'b1; step(); spur_end = 1'b0;
    tick(5);
    check("wait_end_starts", 64'(n_starts - s0), 64'd2);
    check("wait_end_layer", 64'(layer_idx), 64'd1);
    check("wait_end_bram", 64'(BRAM_img_sel), 64'd1);
    spur_end = 1'b1; step(); spur_end = 1'b0;
    wait_done(20);
    check("manual_run_done", 64'(n_done - d0), 64'd1);
    check("manual_run_bram", 64'(BRAM_img_sel), 64'd0);
    step();

    // Asynchronous reset during WAIT of layer 1.
    s0 = n_starts;
    d0 = n_done;
    start_run(4'd3);
    tick(3);
    spur_end = 1'b1; step(); spur_end = 1'b0;
    tick(5);
    check("pre_reset_layer", 64'(layer_idx), 64'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    tick(3);
    rst = 1'b1;
    tick(5);
    check("reset_no_done", 64'(n_done - d0), 64'd0);
    check("reset_idle_busy", 64'(run_busy), 64'd0);
    core_en = 1'b1;
    chk_spacing = 1'b1;
    s0 = n_starts;
    d0 = n_done;
    start_run(4'd1);
    wait_done(60);
    check("post_reset_starts", 64'(n_starts - s0), 64'd1);
    check("post_reset_done", 64'(n_done - d0), 64'd1);
    step();

    // Full-depth run with a core that answers on its first WAIT cycle.
    core_dly = 1;
    s0 = n_starts;
    d0 = n_done;
    start_run(4'd8);
    wait_done(200);
    check("full_starts", 64'(n_starts - s0), 64'd8);
    check("full_done", 64'(n_done - d0), 64'd1);
    check("full_done_after_last", 64'(done_cyc - last_start_cyc), 64'd3);
    check("full_layer_last", 64'(layer_idx), 64'd7);
    check("full_bram_final", 64'(BRAM_img_sel), 64'd0);
    tick(3);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
